// File: rtl/maq_h.sv
`default_nettype none
//============================================================================
// Module      : maq_h
// Description : Hours stage of the clock chain. Keeps the hour as BCD 00-23,
//               counts 0->1 edges of the minutes-stage hour carry, and pulses
//               novo_dia on a carry-driven 23->00 rollover. In adjust mode a
//               synchronised, debounced push button steps the hour instead,
//               and piscar toggles on every 1 Hz tick to blink the display.
// Macro       : FORMATO_12H_EN - when defined, the outputs show the hour in
//               12 h format (01-12) with pm; the internal count stays 00-23.
// Ports       : clock, reset (sync, active-high), enable1hz (1 Hz tick),
//               incrementa_hora (hour carry level), modo_ajuste (adjust mode),
//               botao_hora (raw async button), bcd_h_lsd[3:0], bcd_h_msd[1:0],
//               novo_dia (day pulse), piscar (blink flag), pm (PM flag).
// Revision    : 1.0 - initial release
//============================================================================
module maq_h #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_MAX = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable1hz,
    input  logic       incrementa_hora,
    input  logic       modo_ajuste,
    input  logic       botao_hora,
    output logic [3:0] bcd_h_lsd,
    output logic [1:0] bcd_h_msd,
    output logic       novo_dia,
    output logic       piscar,
    output logic       pm
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_DEB_MAX = c_CNT_W'(DEBOUNCE_MAX);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_AJUSTE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                   r_inc_q;
    logic                   w_carry_evt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_sync;
    logic [c_CNT_W-1:0]     r_deb_cnt;
    logic                   r_btn_stable;
    logic                   r_btn_prev;
    logic                   w_btn_evt;
    logic [3:0]             r_h_lsd;
    logic [1:0]             r_h_msd;
    logic                   w_is_23;
    logic                   w_inc_evt;
    logic                   w_day_wrap;
    logic                   r_novo_dia;
    logic                   r_piscar;
    logic                   w_piscar_next;

    //------------------------------------------------------------------------
    // Hour carry: one event per 0->1 transition of the level input
    //------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inc_q <= 1'b0;
        end else begin
            r_inc_q <= incrementa_hora;
        end
    end

    assign w_carry_evt = incrementa_hora & ~r_inc_q;

    //------------------------------------------------------------------------
    // Button synchroniser and debouncer
    //------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], botao_hora};
        end
    end

    assign w_btn_sync = r_sync[SYNC_STAGES-1];

    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement (a bounce back) restarts the wait.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_deb_cnt    <= '0;
            r_btn_stable <= 1'b0;
            r_btn_prev   <= 1'b0;
        end else begin
            r_btn_prev <= r_btn_stable;
            if (w_btn_sync != r_btn_stable) begin
                if (r_deb_cnt == c_DEB_MAX) begin
                    r_btn_stable <= w_btn_sync;
                    r_deb_cnt    <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign w_btn_evt = r_btn_stable & ~r_btn_prev;

    //------------------------------------------------------------------------
    // Mode state machine
    //------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_is_23 = (r_h_msd == 2'd2) && (r_h_lsd == 4'd3);

    always_comb begin
        w_state_next  = r_state;
        w_inc_evt     = 1'b0;
        w_day_wrap    = 1'b0;
        w_piscar_next = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                // A carry arriving with the switch into adjust is still
                // counted, because the state has not changed yet.
                w_inc_evt  = w_carry_evt;
                w_day_wrap = w_carry_evt & w_is_23;
                if (modo_ajuste) begin
                    w_state_next = ST_AJUSTE;
                end
            end
            ST_AJUSTE: begin
                // Carries are dropped here; only the button steps the hour.
                w_inc_evt = w_btn_evt;
                if (!modo_ajuste) begin
                    w_state_next = ST_NORMAL;
                end else begin
                    w_piscar_next = r_piscar ^ enable1hz;
                end
            end
            default: begin
                w_state_next = ST_NORMAL;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Hour counter, day pulse and blink flag
    //------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h_lsd    <= 4'd0;
            r_h_msd    <= 2'd0;
            r_novo_dia <= 1'b0;
            r_piscar   <= 1'b0;
        end else begin
            r_novo_dia <= w_day_wrap;
            r_piscar   <= w_piscar_next;
            if (w_inc_evt) begin
                if (w_is_23) begin
                    r_h_lsd <= 4'd0;
                    r_h_msd <= 2'd0;
                end else if (r_h_lsd == 4'd9) begin
                    r_h_lsd <= 4'd0;
                    r_h_msd <= r_h_msd + 2'd1;
                end else begin
                    r_h_lsd <= r_h_lsd + 4'd1;
                end
            end
        end
    end

    assign novo_dia = r_novo_dia;
    assign piscar   = r_piscar;

    //------------------------------------------------------------------------
    // Display format
    //------------------------------------------------------------------------
`ifdef FORMATO_12H_EN
    // Conversion done directly on the BCD digits, by tens digit.
    always_comb begin
        bcd_h_lsd = r_h_lsd;
        bcd_h_msd = r_h_msd;
        pm        = 1'b0;
        case (r_h_msd)
            2'd0: begin
                if (r_h_lsd == 4'd0) begin        // 00 -> 12 am
                    bcd_h_msd = 2'd1;
                    bcd_h_lsd = 4'd2;
                end
            end
            2'd1: begin
                if (r_h_lsd == 4'd2) begin        // 12 -> 12 pm
                    pm = 1'b1;
                end else if (r_h_lsd > 4'd2) begin // 13-19 -> 01-07 pm
                    pm        = 1'b1;
                    bcd_h_msd = 2'd0;
                    bcd_h_lsd = r_h_lsd - 4'd2;
                end
            end
            default: begin
                pm = 1'b1;
                if (r_h_lsd < 4'd2) begin         // 20-21 -> 08-09 pm
                    bcd_h_msd = 2'd0;
                    bcd_h_lsd = r_h_lsd + 4'd8;
                end else begin                    // 22-23 -> 10-11 pm
                    bcd_h_msd = 2'd1;
                    bcd_h_lsd = r_h_lsd - 4'd2;
                end
            end
        endcase
    end
`else
    assign bcd_h_lsd = r_h_lsd;
    assign bcd_h_msd = r_h_msd;
    assign pm        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maq_h.sv
`default_nettype none
//============================================================================
// Module      : tb_maq_h
// Description : Directed self-checking bench for maq_h (DEBOUNCE_MAX = 4).
//               Expected displays follow FORMATO_12H_EN when it is defined.
// Revision    : 1.0 - initial release
//============================================================================
module tb_maq_h;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable1hz = 1'b0;
    logic       incrementa_hora = 1'b0;
    logic       modo_ajuste = 1'b0;
    logic       botao_hora = 1'b0;
    logic [3:0] bcd_h_lsd;
    logic [1:0] bcd_h_msd;
    logic       novo_dia;
    logic       piscar;
    logic       pm;

    int total = 0;
    int bad = 0;
    int novo_seen = 0;

    maq_h #(
        .SYNC_STAGES (2),
        .DEBOUNCE_MAX(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable1hz      (enable1hz),
        .incrementa_hora(incrementa_hora),
        .modo_ajuste    (modo_ajuste),
        .botao_hora     (botao_hora),
        .bcd_h_lsd      (bcd_h_lsd),
        .bcd_h_msd      (bcd_h_msd),
        .novo_dia       (novo_dia),
        .piscar         (piscar),
        .pm             (pm)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (novo_dia === 1'b1) novo_seen++;
    end

    // Expected {msd, lsd, pm} shown for a 24 h hour value.
    function automatic logic [6:0] exp_disp(input int h);
        int d;
        logic p;
`ifdef FORMATO_12H_EN
        p = (h >= 12);
        if (h == 0) d = 12;
        else if (h > 12) d = h - 12;
        else d = h;
`else
        p = 1'b0;
        d = h;
`endif
        return {2'(d / 10), 4'(d % 10), p};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic carry_pulse();
        incrementa_hora = 1'b1;
        tick(1);
        incrementa_hora = 1'b0;
        tick(1);
    endtask

    task automatic press();
        botao_hora = 1'b1;
        tick(10);
        botao_hora = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        modo_ajuste = 1'b0;
        botao_hora = 1'b0;
        incrementa_hora = 1'b0;
        enable1hz = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(0)) begin
            bad++;
            $display("FAIL reset_hour got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(0));
        end
        total++;
        if ({novo_dia, piscar} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags got novo/piscar=%b exp=00", {novo_dia, piscar});
        end
    endtask

    task automatic test_hold_carry();
        do_reset();
        novo_seen = 0;
        incrementa_hora = 1'b1;
        tick(100);
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(1)) begin
            bad++;
            $display("FAIL hold_carry got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(1));
        end
        total++;
        if (novo_seen !== 0) begin
            bad++;
            $display("FAIL hold_novo got=%0d exp=0", novo_seen);
        end
        incrementa_hora = 1'b0;
        tick(1);
    endtask

    task automatic test_day_wrap();
        do_reset();
        repeat (23) carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(23)) begin
            bad++;
            $display("FAIL at_23 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(23));
        end
        novo_seen = 0;
        incrementa_hora = 1'b1;
        tick(1);
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm, novo_dia} !== {exp_disp(0), 1'b1}) begin
            bad++;
            $display("FAIL wrap_00 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm, novo_dia}, {exp_disp(0), 1'b1});
        end
        incrementa_hora = 1'b0;
        tick(1);
        total++;
        if (novo_dia !== 1'b0) begin
            bad++;
            $display("FAIL novo_width got=%b exp=0", novo_dia);
        end
        tick(3);
        total++;
        if (novo_seen !== 1) begin
            bad++;
            $display("FAIL novo_count got=%0d exp=1", novo_seen);
        end
    endtask

    task automatic test_bcd_carry();
        do_reset();
        repeat (9) carry_pulse();
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(10)) begin
            bad++;
            $display("FAIL bcd_09_10 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(10));
        end
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(11)) begin
            bad++;
            $display("FAIL disp_11 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(11));
        end
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(12)) begin
            bad++;
            $display("FAIL disp_12 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(12));
        end
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(13)) begin
            bad++;
            $display("FAIL disp_13 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(13));
        end
        repeat (7) carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(20)) begin
            bad++;
            $display("FAIL bcd_19_20 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(20));
        end
    endtask

    task automatic test_adjust();
        do_reset();
        repeat (5) carry_pulse();
        modo_ajuste = 1'b1;
        tick(1);
        // Bounces: single-cycle pulses never outlast the debounce window.
        repeat (5) begin
            botao_hora = 1'b1;
            tick(1);
            botao_hora = 1'b0;
            tick(2);
        end
        tick(10);
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(5)) begin
            bad++;
            $display("FAIL bounce got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(5));
        end
        press();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(6)) begin
            bad++;
            $display("FAIL clean_press got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(6));
        end
        repeat (3) carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(6)) begin
            bad++;
            $display("FAIL carry_in_adjust got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(6));
        end
        for (int i = 0; i < 3; i++) begin
            enable1hz = 1'b1;
            tick(1);
            enable1hz = 1'b0;
            tick(2);
            total++;
            if (piscar !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL piscar_toggle%0d got=%b exp=%b", i, piscar, (i % 2 == 0) ? 1'b1 : 1'b0);
            end
        end
        repeat (17) press();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(23)) begin
            bad++;
            $display("FAIL adj_23 got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(23));
        end
        novo_seen = 0;
        press();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(0) || novo_seen !== 0) begin
            bad++;
            $display("FAIL btn_wrap got=%h novo=%0d exp=%h novo=0", {bcd_h_msd, bcd_h_lsd, pm}, novo_seen, exp_disp(0));
        end
    endtask

    task automatic test_reset_mid();
        repeat (14) press();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm, piscar} !== {exp_disp(14), 1'b1}) begin
            bad++;
            $display("FAIL pre_reset got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm, piscar}, {exp_disp(14), 1'b1});
        end
        botao_hora = 1'b1;
        tick(4);
        reset = 1'b1;
        modo_ajuste = 1'b0;
        botao_hora = 1'b0;
        tick(1);
        reset = 1'b0;
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm, piscar, novo_dia} !== {exp_disp(0), 2'b00}) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm, piscar, novo_dia}, {exp_disp(0), 2'b00});
        end
        tick(1);
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(1)) begin
            bad++;
            $display("FAIL carry_after_reset got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Carry edge together with the switch into adjust mode.
        incrementa_hora = 1'b1;
        modo_ajuste = 1'b1;
        tick(1);
        incrementa_hora = 1'b0;
        tick(1);
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(1)) begin
            bad++;
            $display("FAIL carry_on_mode_entry got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(1));
        end
        // Button event and carry edge in the same cycle: one step only.
        botao_hora = 1'b1;
        tick(7);
        incrementa_hora = 1'b1;
        tick(1);
        incrementa_hora = 1'b0;
        tick(4);
        botao_hora = 1'b0;
        tick(10);
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(2)) begin
            bad++;
            $display("FAIL btn_and_carry got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(2));
        end
        enable1hz = 1'b1;
        tick(1);
        enable1hz = 1'b0;
        modo_ajuste = 1'b0;
        tick(1);
        total++;
        if (piscar !== 1'b0) begin
            bad++;
            $display("FAIL piscar_exit got=%b exp=0", piscar);
        end
        carry_pulse();
        total++;
        if ({bcd_h_msd, bcd_h_lsd, pm} !== exp_disp(3)) begin
            bad++;
            $display("FAIL carry_back_normal got=%h exp=%h", {bcd_h_msd, bcd_h_lsd, pm}, exp_disp(3));
        end
    endtask

    initial begin
        test_reset();
        test_hold_carry();
        test_day_wrap();
        test_bcd_carry();
        test_adjust();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
